alu_issue_seq: RTL and testbench
================================

Name: alu_issue_seq

Overview:
- Upstream driver of the 32-bit ALU: accepts one decoded MIPS-style arithmetic/logic instruction per transaction over a valid/ready handshake.
- Translates opcode/funct into the 4-bit ALU control code, forms operands and drives them on registered ALU ports.
- Captures result and flags, masks meaningless flags, and returns a response over a second valid/ready handshake.
- Sits between the decode stage and the ALU; also maintains a sticky signed-overflow status bit.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU.
- IMM_W, 16, immediate field width.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  sequencer can accept
- in_opcode  in  6  primary opcode
- in_funct  in  6  R-type function field
- in_shamt  in  5  shift amount
- in_rs  in  DATA_W  rs register value
- in_rt  in  DATA_W  rt register value
- in_imm  in  IMM_W  immediate
- alu_a  out  DATA_W  ALU operand A (registered)
- alu_b  out  DATA_W  ALU operand B (registered)
- alu_cntl  out  4  ALU control code (registered)
- alu_out  in  DATA_W  ALU result
- alu_c, alu_n, alu_z, alu_v  in  1 each  ALU carry/negative/zero/overflow
- res_valid  out  1  response available
- res_ready  in  1  consumer accepts response
- res_data  out  DATA_W  captured result
- res_c, res_n, res_z, res_v  out  1 each  masked flags
- res_err  out  1  illegal/unsupported instruction
- ovf_sticky  out  1  set on any signed add/sub overflow
- clr_sticky  in  1  synchronous clear of ovf_sticky

Behaviour:
- Reset: all outputs 0; state IDLE; alu_cntl 4'b0000.
- States: IDLE, EXEC, RESP.
- in_ready = 1 only in IDLE.
- Decode table:
  - Opcode 0x00, by funct: 0x20 add→1010; 0x21 addu→0010; 0x22 sub→1110; 0x23 subu→0110; 0x24 and→0000; 0x25 or→0001; 0x26 xor→0011; 0x27 nor→1100; 0x2A slt→0101; 0x2B sltu→1111; 0x00 sll→1101.
  - I-type opcodes: 0x08 addi→1010; 0x09 addiu→0010; 0x0A slti→0101; 0x0B sltiu→1111; 0x0C andi→0000; 0x0D ori→0001; 0x0E xori→0011.
- Operands:
  - R-type: A=rs, B=rt.
  - sll: A=rt, B=0; legal only when shamt==1.
  - I-type: A=rs, B=imm. andi/ori/xori zero-extend imm; all other I-type ops sign-extend it.
- Anything else is illegal. This includes sll with shamt≠1 and any R-type funct not listed.
- Legal accept in IDLE (in_valid & in_ready):
  - Register alu_a/alu_b/alu_cntl; go to EXEC.
  - ALU is combinational, so at the end of EXEC capture alu_out and flags into res_*; go to RESP.
- Illegal accept: skip EXEC; go straight to RESP with res_err=1, res_data=0, all flags 0.
- RESP: res_valid=1 and res_* held stable until res_valid & res_ready; then return to IDLE.
- Latency: res_valid rises 2 cycles after a legal accept edge and 1 cycle after an illegal one. No back-to-back overlap; throughput is at most 1 op per 3 cycles.
- Flag masking:
  - res_z and res_n always come from the ALU.
  - res_c and res_v come from the ALU only for codes 0010, 0110, 1010, 1110.
  - res_c alone also comes from the ALU for 1101.
  - Otherwise res_c and res_v are forced 0; X from the ALU must never reach res_*.
- Sticky overflow: ovf_sticky is set at EXEC capture when code ∈ {1010, 1110} and alu_v=1. If clr_sticky asserts in the same cycle, set wins.
- In IDLE, alu_* hold their last values.
- Reset mid-operation: immediate return to IDLE; res_valid and ovf_sticky drop asynchronously; the in-flight op is discarded.

Decomposition:
- Shared package holds:
  - ALU control code constants (ALU_AND, ALU_OR, ALU_XOR, ALU_ADDU, ALU_SUBU, ALU_NOR, ALU_NOT, ALU_SLL, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU).
  - Opcode and funct constants.
  - State encoding.
- One combinational sub-module, alu_op_decode: opcode/funct/shamt/imm/rs/rt → cntl, A, B, illegal, flag-mask bits.

Test Plan:
- add: rs=0x7FFFFFFF, rt=1, funct 0x20 → alu_cntl=1010; res_data=0x80000000; res_v=1, res_n=1; ovf_sticky=1; res_valid 2 cycles after accept.
- andi: rs=0xFFFF1234, imm=0x8F0F → B=0x00008F0F; res_data=0x00000204; res_c=0, res_v=0 even though the ALU drives X.
- slti: rs=0xFFFFFFFE, imm=0xFFFF (−1) → B=0xFFFFFFFF, res_data=1. sltiu with the same operands → res_data=1. sltiu with rs=5, imm=3 → res_data=0.
- Illegal funct 0x18 → res_err=1 one cycle after accept, res_data=0; ALU ports unchanged.
- Backpressure: hold res_ready=0 for 5 cycles → res_* stable, in_ready=0, a new in_valid is ignored. After res_ready=1 → next op accepted the following cycle.
- Overflow, then clr_sticky coincident with a second overflow capture → ovf_sticky stays 1. clr_sticky alone → 0. Assert reset_n=0 during EXEC → all outputs 0 immediately and the op is lost.

Source files
------------

// File: rtl/alu_issue_seq_pkg.sv
// Shared ALU control codes, MIPS opcode/funct values and sequencer state encoding.
package alu_issue_seq_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADDU = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_NOT  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SUBU = 4'b0110;
   localparam logic [3:0] ALU_ADD  = 4'b1010;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_SLL  = 4'b1101;
   localparam logic [3:0] ALU_SUB  = 4'b1110;
   localparam logic [3:0] ALU_SLTU = 4'b1111;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_issue_seq_op_decode.sv
// Combinational decode: opcode/funct -> ALU control, operands, legality and flag-mask bits.
module alu_op_decode
   import alu_issue_seq_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16
) (
   input  logic [5:0]        opcode_i,
   input  logic [5:0]        funct_i,
   input  logic [4:0]        shamt_i,
   input  logic [IMM_W-1:0]  imm_i,
   input  logic [DATA_W-1:0] rs_i,
   input  logic [DATA_W-1:0] rt_i,
   output logic [3:0]        cntl_o,
   output logic [DATA_W-1:0] a_o,
   output logic [DATA_W-1:0] b_o,
   output logic              illegal_o,
   output logic              c_en_o,
   output logic              v_en_o,
   output logic              ovf_en_o
);

   logic [DATA_W-1:0] simm;
   logic [DATA_W-1:0] zimm;

   assign simm = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
   assign zimm = {{(DATA_W-IMM_W){1'b0}}, imm_i};

   always_comb begin
      cntl_o    = ALU_AND;
      a_o       = rs_i;
      b_o       = rt_i;
      illegal_o = 1'b0;
      case (opcode_i)
         OP_RTYPE: begin
            case (funct_i)
               FN_ADD:  cntl_o = ALU_ADD;
               FN_ADDU: cntl_o = ALU_ADDU;
               FN_SUB:  cntl_o = ALU_SUB;
               FN_SUBU: cntl_o = ALU_SUBU;
               FN_AND:  cntl_o = ALU_AND;
               FN_OR:   cntl_o = ALU_OR;
               FN_XOR:  cntl_o = ALU_XOR;
               FN_NOR:  cntl_o = ALU_NOR;
               FN_SLT:  cntl_o = ALU_SLT;
               FN_SLTU: cntl_o = ALU_SLTU;
               FN_SLL: begin
                  // The ALU only shifts by one, so any other shamt is unsupported.
                  cntl_o    = ALU_SLL;
                  a_o       = rt_i;
                  b_o       = '0;
                  illegal_o = (shamt_i != 5'd1);
               end
               default: illegal_o = 1'b1;
            endcase
         end
         OP_ADDI:  begin cntl_o = ALU_ADD;  b_o = simm; end
         OP_ADDIU: begin cntl_o = ALU_ADDU; b_o = simm; end
         OP_SLTI:  begin cntl_o = ALU_SLT;  b_o = simm; end
         OP_SLTIU: begin cntl_o = ALU_SLTU; b_o = simm; end
         OP_ANDI:  begin cntl_o = ALU_AND;  b_o = zimm; end
         OP_ORI:   begin cntl_o = ALU_OR;   b_o = zimm; end
         OP_XORI:  begin cntl_o = ALU_XOR;  b_o = zimm; end
         default:  illegal_o = 1'b1;
      endcase
   end

   assign v_en_o   = (cntl_o == ALU_ADDU) || (cntl_o == ALU_SUBU) ||
                     (cntl_o == ALU_ADD)  || (cntl_o == ALU_SUB);
   assign c_en_o   = v_en_o || (cntl_o == ALU_SLL);
   assign ovf_en_o = (cntl_o == ALU_ADD) || (cntl_o == ALU_SUB);

endmodule

// File: rtl/alu_issue_seq.sv
// Issue sequencer for the combinational ALU: IDLE -> EXEC -> RESP, result 2 cycles after a legal accept, 1 after an illegal one.
// in_ready only in IDLE; the response is held stable until res_ready, so at most one op is in flight.
module alu_issue_seq
   import alu_issue_seq_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_opcode,
   input  logic [5:0]        in_funct,
   input  logic [4:0]        in_shamt,
   input  logic [DATA_W-1:0] in_rs,
   input  logic [DATA_W-1:0] in_rt,
   input  logic [IMM_W-1:0]  in_imm,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_cntl,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_c,
   input  logic              alu_n,
   input  logic              alu_z,
   input  logic              alu_v,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              res_c,
   output logic              res_n,
   output logic              res_z,
   output logic              res_v,
   output logic              res_err,
   output logic              ovf_sticky,
   input  logic              clr_sticky
);

   logic [3:0]        dec_cntl;
   logic [DATA_W-1:0] dec_a;
   logic [DATA_W-1:0] dec_b;
   logic              dec_illegal, dec_c_en, dec_v_en, dec_ovf_en;

   alu_op_decode #(.DATA_W(DATA_W), .IMM_W(IMM_W)) u_dec (
      .opcode_i  (in_opcode),
      .funct_i   (in_funct),
      .shamt_i   (in_shamt),
      .imm_i     (in_imm),
      .rs_i      (in_rs),
      .rt_i      (in_rt),
      .cntl_o    (dec_cntl),
      .a_o       (dec_a),
      .b_o       (dec_b),
      .illegal_o (dec_illegal),
      .c_en_o    (dec_c_en),
      .v_en_o    (dec_v_en),
      .ovf_en_o  (dec_ovf_en)
   );

   state_t            state_q;
   logic              in_ready_q, res_valid_q, res_err_q, ovf_sticky_q;
   logic [DATA_W-1:0] alu_a_q, alu_b_q, res_data_q;
   logic [3:0]        alu_cntl_q;
   logic              res_c_q, res_n_q, res_z_q, res_v_q;
   logic              c_en_q, v_en_q, ovf_en_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         in_ready_q   <= 1'b0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_cntl_q   <= ALU_AND;
         res_valid_q  <= 1'b0;
         res_data_q   <= '0;
         res_c_q      <= 1'b0;
         res_n_q      <= 1'b0;
         res_z_q      <= 1'b0;
         res_v_q      <= 1'b0;
         res_err_q    <= 1'b0;
         ovf_sticky_q <= 1'b0;
         c_en_q       <= 1'b0;
         v_en_q       <= 1'b0;
         ovf_en_q     <= 1'b0;
      end else begin
         if (clr_sticky) ovf_sticky_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               in_ready_q <= 1'b1;
               if (in_valid && in_ready_q) begin
                  in_ready_q <= 1'b0;
                  if (dec_illegal) begin
                     // ALU ports keep their previous values on an illegal op.
                     res_valid_q <= 1'b1;
                     res_err_q   <= 1'b1;
                     res_data_q  <= '0;
                     res_c_q     <= 1'b0;
                     res_n_q     <= 1'b0;
                     res_z_q     <= 1'b0;
                     res_v_q     <= 1'b0;
                     state_q     <= ST_RESP;
                  end else begin
                     alu_a_q    <= dec_a;
                     alu_b_q    <= dec_b;
                     alu_cntl_q <= dec_cntl;
                     c_en_q     <= dec_c_en;
                     v_en_q     <= dec_v_en;
                     ovf_en_q   <= dec_ovf_en;
                     state_q    <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               res_valid_q <= 1'b1;
               res_err_q   <= 1'b0;
               res_data_q  <= alu_out;
               res_n_q     <= alu_n;
               res_z_q     <= alu_z;
               // Ternaries keep an undriven ALU carry/overflow out of the response.
               res_c_q     <= c_en_q ? alu_c : 1'b0;
               res_v_q     <= v_en_q ? alu_v : 1'b0;
               if (ovf_en_q && alu_v) ovf_sticky_q <= 1'b1;
               state_q     <= ST_RESP;
            end
            ST_RESP: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               in_ready_q  <= 1'b0;
               res_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_cntl   = alu_cntl_q;
   assign res_valid  = res_valid_q;
   assign res_data   = res_data_q;
   assign res_c      = res_c_q;
   assign res_n      = res_n_q;
   assign res_z      = res_z_q;
   assign res_v      = res_v_q;
   assign res_err    = res_err_q;
   assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: behavioural ALU, instruction-level reference model and response scoreboard.
module tb_alu_issue_seq;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  in_opcode = '0;
   logic [5:0]  in_funct = '0;
   logic [4:0]  in_shamt = '0;
   logic [31:0] in_rs = '0;
   logic [31:0] in_rt = '0;
   logic [15:0] in_imm = '0;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_cntl;
   logic [31:0] alu_out;
   logic        alu_c, alu_n, alu_z, alu_v;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_data;
   logic        res_c, res_n, res_z, res_v, res_err;
   logic        ovf_sticky;
   logic        clr_sticky = 1'b0;

   always #5 clk = ~clk;

   alu_issue_seq #(.DATA_W(32), .IMM_W(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct(in_funct), .in_shamt(in_shamt),
      .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cntl(alu_cntl),
      .alu_out(alu_out), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_c(res_c), .res_n(res_n), .res_z(res_z), .res_v(res_v), .res_err(res_err),
      .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
   );

   // Behavioural 32-bit ALU; carry/overflow are X where they carry no meaning.
   always_comb begin
      logic [32:0] s;
      s       = '0;
      alu_out = '0;
      alu_c   = 1'bx;
      alu_v   = 1'bx;
      case (alu_cntl)
         4'b0010, 4'b1010: begin
            s = {1'b0, alu_a} + {1'b0, alu_b};
            alu_out = s[31:0];
            alu_c = s[32];
            alu_v = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
         end
         4'b0110, 4'b1110: begin
            alu_out = alu_a - alu_b;
            alu_c = (alu_a >= alu_b);
            alu_v = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
         end
         4'b0000: alu_out = alu_a & alu_b;
         4'b0001: alu_out = alu_a | alu_b;
         4'b0011: alu_out = alu_a ^ alu_b;
         4'b1100: alu_out = ~(alu_a | alu_b);
         4'b0101: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
         4'b1111: alu_out = {31'd0, alu_a < alu_b};
         4'b1101: begin alu_out = alu_a << 1; alu_c = alu_a[31]; end
         default: alu_out = '0;
      endcase
      alu_n = alu_out[31];
      alu_z = (alu_out == 32'd0);
   end

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  cntl;
      logic        c, n, z, v, err, ovf;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] last_a = '0, last_b = '0;
   logic [3:0]  last_cntl = '0;
   logic        exp_sticky = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic exp_t ref_model(input logic [5:0] op, input logic [5:0] fn,
                                      input logic [4:0] sh, input logic [31:0] rs,
                                      input logic [31:0] rt, input logic [15:0] imm);
      exp_t        e;
      logic [31:0] a, b, d, si, zi;
      logic [32:0] s;
      logic        ok, sa, c, v;
      int          kind;
      e = '0; ok = 1'b1; sa = 1'b0; a = rs; b = rt; kind = 0; c = 1'b0; v = 1'b0;
      si = {{16{imm[15]}}, imm};
      zi = {16'h0000, imm};
      if (op == 6'h00) begin
         case (fn)
            6'h20: begin kind = 0; e.cntl = 4'b1010; sa = 1'b1; end
            6'h21: begin kind = 0; e.cntl = 4'b0010; end
            6'h22: begin kind = 1; e.cntl = 4'b1110; sa = 1'b1; end
            6'h23: begin kind = 1; e.cntl = 4'b0110; end
            6'h24: begin kind = 2; e.cntl = 4'b0000; end
            6'h25: begin kind = 3; e.cntl = 4'b0001; end
            6'h26: begin kind = 4; e.cntl = 4'b0011; end
            6'h27: begin kind = 5; e.cntl = 4'b1100; end
            6'h2A: begin kind = 6; e.cntl = 4'b0101; end
            6'h2B: begin kind = 7; e.cntl = 4'b1111; end
            6'h00: begin kind = 8; e.cntl = 4'b1101; a = rt; b = 32'd0; ok = (sh == 5'd1); end
            default: ok = 1'b0;
         endcase
      end else begin
         case (op)
            6'h08: begin kind = 0; e.cntl = 4'b1010; sa = 1'b1; b = si; end
            6'h09: begin kind = 0; e.cntl = 4'b0010; b = si; end
            6'h0A: begin kind = 6; e.cntl = 4'b0101; b = si; end
            6'h0B: begin kind = 7; e.cntl = 4'b1111; b = si; end
            6'h0C: begin kind = 2; e.cntl = 4'b0000; b = zi; end
            6'h0D: begin kind = 3; e.cntl = 4'b0001; b = zi; end
            6'h0E: begin kind = 4; e.cntl = 4'b0011; b = zi; end
            default: ok = 1'b0;
         endcase
      end
      case (kind)
         0: begin
            s = {1'b0, a} + {1'b0, b}; d = s[31:0]; c = s[32];
            v = (a[31] == b[31]) && (d[31] != a[31]);
         end
         1: begin d = a - b; c = (a >= b); v = (a[31] != b[31]) && (d[31] != a[31]); end
         2: d = a & b;
         3: d = a | b;
         4: d = a ^ b;
         5: d = ~(a | b);
         6: d = {31'd0, $signed(a) < $signed(b)};
         7: d = {31'd0, a < b};
         default: begin d = a << 1; c = a[31]; end
      endcase
      if (ok) begin
         e.data = d; e.a = a; e.b = b; e.c = c; e.v = v;
         e.n = d[31]; e.z = (d == 32'd0); e.ovf = sa & v;
      end else begin
         e.err = 1'b1;
      end
      return e;
   endfunction

   task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                        input int hold, input bit clr_exec);
      exp_t e, g;
      int   k, lat;
      e = ref_model(op, fn, sh, rs, rt, imm);
      if (e.err) begin
         e.a = last_a; e.b = last_b; e.cntl = last_cntl;
      end else begin
         last_a = e.a; last_b = e.b; last_cntl = e.cntl;
      end
      sb.push_back(e);
      @(negedge clk);
      in_opcode = op; in_funct = fn; in_shamt = sh; in_rs = rs; in_rt = rt; in_imm = imm;
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 20) begin @(negedge clk); k++; end
      chk("accept_timeout", 64'(k < 20), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      if (clr_exec) clr_sticky = 1'b1;
      lat = 1;
      while (!res_valid && lat < 8) begin @(negedge clk); clr_sticky = 1'b0; lat++; end
      clr_sticky = 1'b0;
      chk("latency", 64'(lat), e.err ? 64'd1 : 64'd2);
      if (e.ovf) exp_sticky = 1'b1;
      else if (clr_exec) exp_sticky = 1'b0;
      g = sb.pop_front();
      chk("res_data", 64'(res_data), 64'(g.data));
      chk("res_flags_cnzv", 64'({res_c, res_n, res_z, res_v}), 64'({g.c, g.n, g.z, g.v}));
      chk("res_err", 64'(res_err), 64'(g.err));
      chk("alu_a", 64'(alu_a), 64'(g.a));
      chk("alu_b", 64'(alu_b), 64'(g.b));
      chk("alu_cntl", 64'(alu_cntl), 64'(g.cntl));
      chk("ovf_sticky", 64'(ovf_sticky), 64'(exp_sticky));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; in_opcode = 6'h00; in_funct = 6'h20; in_rs = $urandom; in_rt = $urandom;
         @(negedge clk);
         chk("hold_data", 64'({res_valid, in_ready, res_err, res_data}), 64'({1'b1, 1'b0, g.err, g.data}));
      end
      in_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("release_valid", 64'(res_valid), 64'd0);
      chk("release_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [5:0] rfn [11];
      logic [5:0] iop [7];
      rfn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00};
      iop = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E};

      #12;
      chk("rst_outs", 64'({in_ready, res_valid, res_err, ovf_sticky, alu_cntl}), 64'd0);
      chk("rst_data", 64'({alu_a, res_data}), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      issue(6'h00, 6'h20, 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 16'h0, 0, 1'b0);
      issue(6'h0C, 6'h00, 5'd0, 32'hFFFF_1234, 32'h0, 16'h8F0F, 0, 1'b0);
      issue(6'h0A, 6'h00, 5'd0, 32'hFFFF_FFFE, 32'h0, 16'hFFFF, 0, 1'b0);
      issue(6'h0B, 6'h00, 5'd0, 32'hFFFF_FFFE, 32'h0, 16'hFFFF, 0, 1'b0);
      issue(6'h0B, 6'h00, 5'd0, 32'h0000_0005, 32'h0, 16'h0003, 0, 1'b0);
      issue(6'h00, 6'h18, 5'd0, 32'h1111_1111, 32'h2222_2222, 16'h0, 0, 1'b0);
      issue(6'h00, 6'h00, 5'd2, 32'h0, 32'h8000_0001, 16'h0, 0, 1'b0);
      issue(6'h00, 6'h00, 5'd1, 32'h0, 32'h8000_0001, 16'h0, 0, 1'b0);
      issue(6'h23, 6'h20, 5'd0, 32'h5, 32'h6, 16'h0, 0, 1'b0);
      issue(6'h00, 6'h22, 5'd0, 32'h8000_0000, 32'h0000_0001, 16'h0, 0, 1'b0);
      issue(6'h00, 6'h23, 5'd0, 32'h0000_0003, 32'h0000_0005, 16'h0, 0, 1'b0);
      issue(6'h00, 6'h27, 5'd0, 32'hF0F0_0000, 32'h0F0F_0000, 16'h0, 0, 1'b0);
      issue(6'h08, 6'h00, 5'd0, 32'h0000_0010, 32'h0, 16'hFFF0, 0, 1'b0);
      issue(6'h0E, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'h0, 16'h8000, 5, 1'b0);

      issue(6'h00, 6'h20, 5'd0, 32'h8000_0000, 32'h8000_0000, 16'h0, 0, 1'b1);
      @(negedge clk);
      clr_sticky = 1'b1;
      @(negedge clk);
      clr_sticky = 1'b0;
      exp_sticky = 1'b0;
      chk("sticky_clear", 64'(ovf_sticky), 64'd0);

      for (int i = 0; i < 16; i++) begin
         int sel;
         sel = $urandom_range(0, 17);
         if (sel < 11) issue(6'h00, rfn[sel], 5'd1, $urandom, $urandom, 16'(($urandom)), 0, 1'b0);
         else issue(iop[sel-11], 6'h00, 5'd0, $urandom, $urandom, 16'(($urandom)), 0, 1'b0);
      end

      issue(6'h00, 6'h22, 5'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 16'h0, 0, 1'b0);
      @(negedge clk);
      in_opcode = 6'h00; in_funct = 6'h21; in_rs = 32'h1234_5678; in_rt = 32'h1; in_valid = 1'b1;
      for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_mid_outs", 64'({in_ready, res_valid, res_err, ovf_sticky, alu_cntl}), 64'd0);
      chk("rst_mid_alu", 64'({alu_a, alu_b}), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      last_a = '0; last_b = '0; last_cntl = '0; exp_sticky = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_op_lost", 64'({res_valid, res_data}), 64'd0);
      issue(6'h0D, 6'h00, 5'd0, 32'hA000_0000, 32'h0, 16'h00FF, 0, 1'b0);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
